// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: shares one 16->32-bit immediate extension unit between
// the ALU operand path (A) and the branch/jump target path (B). The block
// arbitrates round-robin or with fixed A priority, extends the granted
// immediate, and holds the result in a one-entry valid/ready output register.
`timescale 1ns/1ps

module imm_ext_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_imm,
  input  logic [1:0]  a_mode,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [15:0] b_imm,
  input  logic [1:0]  b_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_owner
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic [31:0] r_out_data;
  logic        r_out_owner;

  logic        w_accept;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_hs_a;
  logic        w_hs_b;
  logic [15:0] w_imm;
  logic [1:0]  w_mode;
  logic [31:0] w_ext;

  // Slot availability and arbitration; rst_n gating keeps both readies low
  // while reset is held, since the EMPTY reset state would otherwise accept.
  always_comb begin
    w_accept  = rst_n & ((r_state == ST_EMPTY) | out_ready);
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if ((RR_EN != 0) && (r_last_grant == 1'b0)) begin
        w_grant_b = 1'b1;
      end else begin
        w_grant_a = 1'b1;
      end
    end else begin
      w_grant_a = a_valid;
      w_grant_b = b_valid;
    end
  end

  assign a_ready = w_accept & w_grant_a;
  assign b_ready = w_accept & w_grant_b;
  assign w_hs_a  = a_valid & a_ready;
  assign w_hs_b  = b_valid & b_ready;

  // Select the granted operand and extend it according to its mode
  always_comb begin
    w_imm  = w_hs_b ? b_imm  : a_imm;
    w_mode = w_hs_b ? b_mode : a_mode;
    w_ext  = '0;
    unique case (w_mode)
      2'b00: w_ext = {{16{w_imm[15]}}, w_imm};
      2'b01: w_ext = {16'h0000, w_imm};
      2'b10: w_ext = {w_imm, 16'h0000};
      2'b11: w_ext = {{14{w_imm[15]}}, w_imm, 2'b00};
      default: w_ext = '0;
    endcase
  end

  // Output register FSM: load on handshake, drain when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_out_data   <= '0;
      r_out_owner  <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_hs_a || w_hs_b) begin
        r_state      <= ST_FULL;
        r_out_data   <= w_ext;
        r_out_owner  <= w_hs_b;
        r_last_grant <= w_hs_b;
      end else if ((r_state == ST_FULL) && out_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_owner = r_out_owner;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Testbench for imm_ext_arbiter: a round-robin and a fixed-priority instance
// are each paired with a queue-based reference model and a monitor.
`timescale 1ns/1ps

module tb_imm_ext_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_phase = 1'b0;

  logic        d_av = 1'b0, d_bv = 1'b0, out_ready = 1'b0;
  logic [15:0] d_aimm = '0, d_bimm = '0;
  logic [1:0]  d_amode = '0, d_bmode = '0;

  logic        w_av[2], w_bv[2];
  logic [15:0] w_aimm[2], w_bimm[2];
  logic [1:0]  w_amode[2], w_bmode[2];
  logic        w_ar[2], w_br[2], w_ov[2], w_oo[2];
  logic [31:0] w_od[2];

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Extension by value arithmetic
  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
    int s;
    s = int'($signed(v));
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(v);
      2'd2:    return 32'(v) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  // Returns {grant_b, grant_a}
  function automatic logic [1:0] ref_gnt(input bit rr, input bit last, input bit av, input bit bv);
    if (av && bv) return (rr && !last) ? 2'b10 : 2'b01;
    return {bv, av};
  endfunction

  imm_ext_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_valid(w_av[0]), .a_ready(w_ar[0]), .a_imm(w_aimm[0]), .a_mode(w_amode[0]),
    .b_valid(w_bv[0]), .b_ready(w_br[0]), .b_imm(w_bimm[0]), .b_mode(w_bmode[0]),
    .out_valid(w_ov[0]), .out_ready(out_ready), .out_data(w_od[0]), .out_owner(w_oo[0])
  );

  imm_ext_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(w_av[1]), .a_ready(w_ar[1]), .a_imm(w_aimm[1]), .a_mode(w_amode[1]),
    .b_valid(w_bv[1]), .b_ready(w_br[1]), .b_imm(w_bimm[1]), .b_mode(w_bmode[1]),
    .out_valid(w_ov[1]), .out_ready(out_ready), .out_data(w_od[1]), .out_owner(w_oo[1])
  );

  for (genvar g = 0; g < 2; g++) begin : gch
    localparam bit RR = (g == 0);
    exp_t        q[$];
    bit          last = 1'b1;
    bit          hs_a = 1'b0, hs_b = 1'b0;
    logic        r_av = 1'b0, r_bv = 1'b0;
    logic [15:0] r_aimm = '0, r_bimm = '0;
    logic [1:0]  r_amode = '0, r_bmode = '0;
    bit          pa = 1'b0, pb = 1'b0, prev_rand = 1'b0;
    logic [17:0] sa = '0, sb = '0;

    assign w_av[g]    = rand_phase ? r_av    : d_av;
    assign w_aimm[g]  = rand_phase ? r_aimm  : d_aimm;
    assign w_amode[g] = rand_phase ? r_amode : d_amode;
    assign w_bv[g]    = rand_phase ? r_bv    : d_bv;
    assign w_bimm[g]  = rand_phase ? r_bimm  : d_bimm;
    assign w_bmode[g] = rand_phase ? r_bmode : d_bmode;

    always @(negedge rst_n) begin
      q.delete();
      last = 1'b1;
    end

    // Reference model: a non-empty queue at the edge means the slot stays
    // occupied (the monitor already removed anything consumed at this edge)
    always @(posedge clk) begin
      logic [1:0] gn;
      hs_a = 1'b0;
      hs_b = 1'b0;
      if (rst_n) begin
        gn = ref_gnt(RR, last, w_av[g], w_bv[g]);
        if (q.size() == 0) begin
          hs_a = gn[0];
          hs_b = gn[1];
        end
        if (hs_a) begin
          q.push_back('{d: ref_ext(w_aimm[g], w_amode[g]), o: 1'b0});
          last = 1'b0;
        end else if (hs_b) begin
          q.push_back('{d: ref_ext(w_bimm[g], w_bmode[g]), o: 1'b1});
          last = 1'b1;
        end
      end
      if (rand_phase) begin
        #1;
        if (!r_av || hs_a) begin
          r_av    = ($urandom_range(0, 3) != 0);
          r_aimm  = 16'($urandom);
          r_amode = 2'($urandom);
        end
        if (!r_bv || hs_b) begin
          r_bv    = ($urandom_range(0, 3) != 0);
          r_bimm  = 16'($urandom);
          r_bmode = 2'($urandom);
        end
      end
    end

    // Monitor: compare outputs and readies, retire consumed results
    always @(negedge clk) begin
      logic [1:0] gn;
      bit acc;
      chk($sformatf("g%0d out_valid", g), 32'(w_ov[g]), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk($sformatf("g%0d out_data", g), w_od[g], q[0].d);
        chk($sformatf("g%0d out_owner", g), 32'(w_oo[g]), 32'(q[0].o));
      end
      acc = rst_n && ((q.size() == 0) || out_ready);
      gn  = ref_gnt(RR, last, w_av[g], w_bv[g]);
      chk($sformatf("g%0d a_ready", g), 32'(w_ar[g]), 32'(acc && gn[0]));
      chk($sformatf("g%0d b_ready", g), 32'(w_br[g]), 32'(acc && gn[1]));
      if (rand_phase && prev_rand) begin
        if (pa) chk($sformatf("g%0d A hold", g), 32'({w_av[g], w_aimm[g], w_amode[g]}), 32'({1'b1, sa}));
        if (pb) chk($sformatf("g%0d B hold", g), 32'({w_bv[g], w_bimm[g], w_bmode[g]}), 32'({1'b1, sb}));
      end
      pa = w_av[g] && !w_ar[g];
      pb = w_bv[g] && !w_br[g];
      sa = {w_aimm[g], w_amode[g]};
      sb = {w_bimm[g], w_bmode[g]};
      prev_rand = rand_phase;
      if ((q.size() != 0) && out_ready) void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bexp[3];

  initial begin
    bexp[0] = 32'h00008001;
    bexp[1] = 32'h80010000;
    bexp[2] = 32'hFFFFFFFC;

    // Reset state, readies gated while reset is held
    d_av = 1'b1;
    d_bv = 1'b1;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("reset out_valid", 32'(w_ov[i]), 32'd0);
      chk("reset out_data", w_od[i], 32'd0);
      chk("reset out_owner", 32'(w_oo[i]), 32'd0);
      chk("reset a_ready", 32'(w_ar[i]), 32'd0);
      chk("reset b_ready", 32'(w_br[i]), 32'd0);
    end
    #10;
    d_av = 1'b0;
    d_bv = 1'b0;
    rst_n = 1'b1;

    // A only, sign extend
    step();
    d_av = 1'b1; d_aimm = 16'h8001; d_amode = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    chk("A only a_ready", 32'(w_ar[0]), 32'd1);
    step();
    d_av = 1'b0;
    @(negedge clk);
    chk("A only out_valid", 32'(w_ov[0]), 32'd1);
    chk("A only out_data", w_od[0], 32'hFFFF8001);
    chk("A only out_owner", 32'(w_oo[0]), 32'd0);

    // Mode sweep through B
    for (int i = 0; i < 3; i++) begin
      step();
      d_bv = 1'b1;
      d_bimm = (i == 2) ? 16'hFFFF : 16'h8001;
      d_bmode = 2'(i + 1);
      @(negedge clk);
      chk("B sweep b_ready", 32'(w_br[0]), 32'd1);
      step();
      d_bv = 1'b0;
      @(negedge clk);
      chk("B sweep out_data", w_od[0], bexp[i]);
      chk("B sweep out_owner", 32'(w_oo[0]), 32'd1);
    end

    // Both valid: alternation vs fixed priority, no bubbles
    step();
    d_av = 1'b1; d_aimm = 16'h0011; d_amode = 2'd1;
    d_bv = 1'b1; d_bimm = 16'h0022; d_bmode = 2'd1;
    @(negedge clk);
    chk("fp b_ready contended", 32'(w_br[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr owner seq", 32'(w_oo[0]), 32'(k % 2));
      chk("rr no bubble", 32'(w_ov[0]), 32'd1);
      chk("fp owner seq", 32'(w_oo[1]), 32'd0);
      chk("fp b_ready contended", 32'(w_br[1]), 32'd0);
    end
    step();
    d_av = 1'b0; d_bv = 1'b0;

    // Backpressure while holding 32'h00001234
    step();
    d_av = 1'b1; d_aimm = 16'h1234; d_amode = 2'd1;
    step();
    out_ready = 1'b0;
    d_aimm = 16'h5555;
    d_bv = 1'b1; d_bimm = 16'h7777; d_bmode = 2'd1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("stall a_ready", 32'(w_ar[i]), 32'd0);
        chk("stall b_ready", 32'(w_br[i]), 32'd0);
        chk("stall out_data", w_od[i], 32'h00001234);
      end
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("refill rr b_ready", 32'(w_br[0]), 32'd1);
    chk("refill fp a_ready", 32'(w_ar[1]), 32'd1);
    @(negedge clk);
    chk("refill rr out_valid", 32'(w_ov[0]), 32'd1);
    chk("refill rr out_data", w_od[0], 32'h00007777);
    chk("refill rr out_owner", 32'(w_oo[0]), 32'd1);
    chk("refill fp out_data", w_od[1], 32'h00005555);

    // Reset while FULL
    step();
    out_ready = 1'b0; d_av = 1'b0; d_bv = 1'b0;
    @(negedge clk);
    chk("pre-reset out_valid", 32'(w_ov[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid reset out_valid", 32'(w_ov[i]), 32'd0);
      chk("mid reset out_data", w_od[i], 32'd0);
      chk("mid reset a_ready", 32'(w_ar[i]), 32'd0);
    end
    d_av = 1'b1; d_aimm = 16'h00AA; d_amode = 2'd1;
    d_bv = 1'b1; d_bimm = 16'h00BB; d_bmode = 2'd1;
    out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset rr a_ready", 32'(w_ar[0]), 32'd1);
    chk("post reset rr b_ready", 32'(w_br[0]), 32'd0);
    @(negedge clk);
    chk("post reset rr owner", 32'(w_oo[0]), 32'd0);
    chk("post reset rr data", w_od[0], 32'h000000AA);

    // Drain to empty, then confirm idle cycles leave last_grant alone
    step();
    d_av = 1'b0; d_bv = 1'b0;
    @(negedge clk);
    chk("drain full", 32'(w_ov[0]), 32'd1);
    @(negedge clk);
    chk("drain rr empty", 32'(w_ov[0]), 32'd0);
    chk("drain fp empty", 32'(w_ov[1]), 32'd0);
    repeat (3) @(negedge clk);
    step();
    d_av = 1'b1; d_bv = 1'b1;
    @(negedge clk);
    chk("idle keeps last rr a_ready", 32'(w_ar[0]), 32'd1);
    chk("idle keeps last rr b_ready", 32'(w_br[0]), 32'd0);
    step();
    d_av = 1'b0; d_bv = 1'b0;

    // Randomized traffic with random consumer stalls
    step();
    rand_phase = 1'b1;
    repeat (3000) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    rand_phase = 1'b0;
    d_av = 1'b0; d_bv = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
